processed_frame_scanout: RTL and testbench

- Reader end of the processed-image memory. The image processor writes a 400x300 RGB444 frame into that memory and raises all_ready.
- This block reads the frame back through the memory's read port and streams it to a 640x480@60 VGA output.
- The image is placed in a fixed window; everything outside the window is black.
- Sync generation never stops, so the monitor keeps lock while the processor rewrites the frame.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_timing_gen.sv | 67 ++++++
 rtl/processed_frame_scanout.sv | 150 +++++++++++++++
 tb/tb_processed_frame_scanout.sv | 138 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and the scanout state encoding.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = 800;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = 525;

  typedef enum logic {
    WAIT_READY = 1'b0,
    SHOW       = 1'b1
  } scan_state_e;

endpackage

// File: rtl/vga_timing_gen.sv
// Tick-enabled horizontal/vertical counters with active-area and raw (active-low) sync decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FRONT = H_FP,
  parameter int H_SYNCW = H_SYNC,
  parameter int H_TOT   = H_TOTAL,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_SYNCW = V_SYNC,
  parameter int V_TOT   = V_TOTAL,
  parameter int HW      = $clog2(H_TOT),
  parameter int VW      = $clog2(V_TOT)
) (
  input  logic          clk_p,
  input  logic          rst,
  input  logic          tick,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          active,
  output logic          hsync_raw,
  output logic          vsync_raw
);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT_L = HW'(H_ACT);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACT + H_FRONT);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACT + H_FRONT + H_SYNCW);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT_L = VW'(V_ACT);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACT + V_FRONT);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACT + V_FRONT + V_SYNCW);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_p) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h         = h_q;
  assign v         = v_q;
  assign active    = (h_q < H_ACT_L) && (v_q < V_ACT_L);
  assign hsync_raw = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign vsync_raw = !((v_q >= VS_BEG) && (v_q < VS_END));

endmodule

// File: rtl/processed_frame_scanout.sv
// Streams the processed frame from memory to VGA inside a fixed window; frame
// choice (image or black) is latched only at frame boundaries.
module processed_frame_scanout
  import vga_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 19,
  parameter int IMG_W      = 400,
  parameter int IMG_H      = 300,
  parameter int X_OFF      = 120,
  parameter int Y_OFF      = 90,
  parameter int CLK_DIV    = 4,
  parameter int H_ACT      = H_ACTIVE,
  parameter int H_FRONT    = H_FP,
  parameter int H_SYNCW    = H_SYNC,
  parameter int H_TOT      = H_TOTAL,
  parameter int V_ACT      = V_ACTIVE,
  parameter int V_FRONT    = V_FP,
  parameter int V_SYNCW    = V_SYNC,
  parameter int V_TOT      = V_TOTAL
) (
  input  logic                  clk_p,
  input  logic                  rst,
  input  logic                  all_ready,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start
);

  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0]         DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0]         X_BEG     = HW'(X_OFF);
  localparam logic [HW-1:0]         X_END     = HW'(X_OFF + IMG_W);
  localparam logic [VW-1:0]         Y_BEG     = VW'(Y_OFF);
  localparam logic [VW-1:0]         Y_END     = VW'(Y_OFF + IMG_H);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(IMG_W * IMG_H - 1);

  logic [HW-1:0] h_s;
  logic [VW-1:0] v_s;
  logic          active_s, hsync_raw_s, vsync_raw_s;
  logic          tick_s, boundary_s, in_win_s;

  logic [DW-1:0]         div_q, div_d;
  scan_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [DATA_WIDTH-1:0] pix_s1_q, pix_s1_d;
  logic                  show_s1_q, show_s1_d;
  logic                  hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
  logic [DATA_WIDTH-1:0] rgb_q, rgb_d;
  logic                  hsync_q, hsync_d, vsync_q, vsync_d;
  logic                  frame_start_q, frame_start_d;

  vga_timing_gen #(
    .H_ACT(H_ACT), .H_FRONT(H_FRONT), .H_SYNCW(H_SYNCW), .H_TOT(H_TOT),
    .V_ACT(V_ACT), .V_FRONT(V_FRONT), .V_SYNCW(V_SYNCW), .V_TOT(V_TOT),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk_p    (clk_p),
    .rst      (rst),
    .tick     (tick_s),
    .h        (h_s),
    .v        (v_s),
    .active   (active_s),
    .hsync_raw(hsync_raw_s),
    .vsync_raw(vsync_raw_s)
  );

  assign tick_s     = (div_q == DIV_LAST);
  assign boundary_s = tick_s && (h_s == '0) && (v_s == '0);
  assign in_win_s   = (h_s >= X_BEG) && (h_s < X_END) && (v_s >= Y_BEG) && (v_s < Y_END);

  always_comb begin
    div_d         = tick_s ? '0 : div_q + 1'b1;
    state_d       = state_q;
    r_addr_d      = r_addr_q;
    pix_s1_d      = pix_s1_q;
    show_s1_d     = show_s1_q;
    hs_s1_d       = hs_s1_q;
    vs_s1_d       = vs_s1_q;
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = boundary_s;
    if (tick_s) begin
      // The address saturates so it rests on the last image pixel until the next frame.
      if (boundary_s) begin
        state_d  = all_ready ? SHOW : WAIT_READY;
        r_addr_d = '0;
      end else if (in_win_s && (r_addr_q != ADDR_LAST)) begin
        r_addr_d = r_addr_q + 1'b1;
      end else begin
        r_addr_d = r_addr_q;
      end
      // r_addr has been stable for the whole tick, so r_data already matches it here.
      pix_s1_d  = r_data;
      show_s1_d = in_win_s && active_s && (state_q == SHOW);
      hs_s1_d   = hsync_raw_s;
      vs_s1_d   = vsync_raw_s;
      rgb_d     = show_s1_q ? pix_s1_q : '0;
      hsync_d   = hs_s1_q;
      vsync_d   = vs_s1_q;
    end else begin
      rgb_d = rgb_q;
    end
  end

  always_ff @(posedge clk_p) begin
    if (rst) begin
      div_q         <= '0;
      state_q       <= WAIT_READY;
      r_addr_q      <= '0;
      pix_s1_q      <= '0;
      show_s1_q     <= 1'b0;
      hs_s1_q       <= 1'b1;
      vs_s1_q       <= 1'b1;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      state_q       <= state_d;
      r_addr_q      <= r_addr_d;
      pix_s1_q      <= pix_s1_d;
      show_s1_q     <= show_s1_d;
      hs_s1_q       <= hs_s1_d;
      vs_s1_q       <= vs_s1_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign r_addr      = r_addr_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_processed_frame_scanout.sv
// Scoreboard bench for processed_frame_scanout on a scaled-down raster so whole frames fit in a short run.
module tb_processed_frame_scanout;

  localparam int CLK_DIV = 2;
  localparam int H_ACT = 40, H_FRONT = 4, H_SYNCW = 8, H_TOT = 60;
  localparam int V_ACT = 30, V_FRONT = 2, V_SYNCW = 2, V_TOT = 38;
  localparam int IMG_W = 20, IMG_H = 12, X_OFF = 10, Y_OFF = 6;
  localparam int LAST_ADDR = IMG_W * IMG_H - 1;

  logic        clk_p = 1'b0;
  logic        rst;
  logic        all_ready;
  logic [18:0] r_addr;
  logic [11:0] r_data = 12'h000;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync, vsync, frame_start;

  processed_frame_scanout #(
    .DATA_WIDTH(12), .ADDR_WIDTH(19), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .X_OFF(X_OFF), .Y_OFF(Y_OFF), .CLK_DIV(CLK_DIV),
    .H_ACT(H_ACT), .H_FRONT(H_FRONT), .H_SYNCW(H_SYNCW), .H_TOT(H_TOT),
    .V_ACT(V_ACT), .V_FRONT(V_FRONT), .V_SYNCW(V_SYNCW), .V_TOT(V_TOT)
  ) dut (
    .clk_p(clk_p), .rst(rst), .all_ready(all_ready), .r_addr(r_addr), .r_data(r_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start)
  );

  always #5 clk_p = ~clk_p;

  // Memory model: one-cycle read latency, content = low 12 address bits.
  always @(posedge clk_p) r_data <= r_addr[11:0];

  int n_cmp = 0;
  int n_bad = 0;

  int m_div = 0, m_h = 0, m_v = 0, m_addr = 0;
  bit m_show = 1'b0;
  bit exp_fs = 1'b0;
  logic [13:0] exp_pins = {12'h000, 2'b11};
  logic [13:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t (model h=%0d v=%0d): got %h, expected %h", tag, $time, m_h, m_v, obs, exp);
    end
  endtask

  // One clk_p: advance the reference model across the edge, then compare all outputs.
  task automatic step();
    bit          tk, bnd, win, hs, vs;
    logic [11:0] col;
    logic [11:0] addr12;
    tk  = (m_div == CLK_DIV - 1);
    bnd = tk && (m_h == 0) && (m_v == 0);
    @(posedge clk_p);
    if (rst) begin
      m_div = 0; m_h = 0; m_v = 0; m_addr = 0; m_show = 1'b0;
      exp_q.delete();
      exp_fs   = 1'b0;
      exp_pins = {12'h000, 2'b11};
    end else begin
      exp_fs = bnd;
      if (tk) begin
        win    = (m_h >= X_OFF) && (m_h < X_OFF + IMG_W) && (m_v >= Y_OFF) && (m_v < Y_OFF + IMG_H);
        addr12 = m_addr[11:0];
        col    = (win && m_show) ? addr12 : 12'h000;
        hs     = !((m_h >= H_ACT + H_FRONT) && (m_h < H_ACT + H_FRONT + H_SYNCW));
        vs     = !((m_v >= V_ACT + V_FRONT) && (m_v < V_ACT + V_FRONT + V_SYNCW));
        exp_q.push_back({col, hs, vs});
        if (exp_q.size() > 1) exp_pins = exp_q.pop_front();
        if (bnd) begin
          m_show = all_ready;
          m_addr = 0;
        end else if (win && (m_addr != LAST_ADDR)) begin
          m_addr = m_addr + 1;
        end
        if (m_h == H_TOT - 1) begin
          m_h = 0;
          m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
        end else begin
          m_h = m_h + 1;
        end
        m_div = 0;
      end else begin
        m_div = m_div + 1;
      end
    end
    #1;
    check_val("pins", {18'd0, vga_r, vga_g, vga_b, hsync, vsync}, {18'd0, exp_pins});
    check_val("frame_start", {31'd0, frame_start}, {31'd0, exp_fs});
    check_val("r_addr", {13'd0, r_addr}, m_addr);
  endtask

  // Run until the model counter sits at (v, h); a blown budget is reported as a failure.
  task automatic run_to(input int v, input int h);
    int budget;
    budget = 2 * H_TOT * V_TOT * CLK_DIV + 16;
    while (!((m_v == v) && (m_h == h)) && (budget > 0)) begin
      step();
      budget--;
    end
    if (budget == 0) check_val("wait", m_v * H_TOT + m_h, v * H_TOT + h);
  endtask

  initial begin
    rst       = 1'b1;
    all_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Frame 0 stays black; all_ready rises just before the boundary so frame 1 shows.
    run_to(V_TOT - 1, H_TOT - 5);
    all_ready = 1'b1;
    run_to(0, 1);
    // Drop mid-frame: rest of frame 1 still shows, frame 2 black.
    run_to(20, 0);
    all_ready = 1'b0;
    run_to(0, 1);
    // Rise mid-frame in WAIT_READY: frame 2 stays black, frame 3 shows.
    run_to(10, 0);
    all_ready = 1'b1;
    run_to(0, 1);
    // One-cycle reset in the middle of frame 3, then restart straight into SHOW.
    run_to(15, 30);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_to(V_TOT - 1, 0);
    run_to(20, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
